// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: configuration, control and serial-stream signals of the pattern detector
interface seq_detect_ctrl_if #(
    parameter int MAXLEN = 8,
    parameter int CW     = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [3:0]        cfg_len;
    logic              cfg_overlap;
    logic [CW-1:0]     cfg_target;
    logic              cfg_err;
    logic              start;
    logic              abort;
    logic              x;
    logic              x_valid;
    logic              y;
    logic [CW-1:0]     match_count;
    logic              busy;
    logic              done;
    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, x, x_valid,
        input  cfg_ready, cfg_err, y, match_count, busy, done
    );
    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, x, x_valid,
        output cfg_ready, cfg_err, y, match_count, busy, done
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time configurable serial pattern detector with Mealy match strobe and match counter
module seq_detect_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CW     = 8
) (
    input logic           clk,
    input logic           reset,
    seq_detect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state_q, state_d;
    logic [MAXLEN-1:0] pattern_q, pattern_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        fill_q, fill_d;
    logic              overlap_q, overlap_d;
    logic [CW-1:0]     target_q, target_d;
    logic [CW-1:0]     count_q, count_d;
    logic [MAXLEN-2:0] hist_q, hist_d;
    logic              cfg_err_q, cfg_err_d;
    logic [MAXLEN-1:0] win;
    logic [MAXLEN-1:0] diff_sh;
    logic              legal, full, hit, y;

    // Match window (history plus current bit) compared only over the low len bits; next state
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        count_d   = count_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cfg_err_d = 1'b0;
        win       = {hist_q, bus.x};
        diff_sh   = (win ^ pattern_q) << (4'(MAXLEN) - len_q);
        hit       = diff_sh == '0;
        full      = fill_q == len_q - 4'd1;
        legal     = bus.cfg_len >= 4'd2 && bus.cfg_len <= 4'(MAXLEN);
        y         = state_q == RUN && bus.x_valid && !bus.abort && full && hit;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid && legal) begin
                    pattern_d = bus.cfg_pattern;
                    len_d     = bus.cfg_len;
                    overlap_d = bus.cfg_overlap;
                    target_d  = bus.cfg_target;
                end
                cfg_err_d = bus.cfg_valid && !legal;
                if (bus.start) begin
                    state_d = RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    count_d = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.x_valid) begin
                    if (y) begin
                        count_d = (count_q == '1) ? count_q : count_q + CW'(1);
                        hist_d  = overlap_q ? win[MAXLEN-2:0] : '0;
                        fill_d  = overlap_q ? fill_q : 4'd0;
                        if (target_q != '0 && count_q + CW'(1) == target_q) state_d = DONE;
                    end else begin
                        hist_d = win[MAXLEN-2:0];
                        fill_d = full ? fill_q : fill_q + 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= 4'd2;
            overlap_q <= 1'b0;
            target_q  <= '0;
            count_q   <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            count_q   <= count_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.cfg_ready   = state_q == IDLE;
    assign bus.busy        = state_q == RUN;
    assign bus.done        = state_q == DONE;
    assign bus.y           = y;
    assign bus.match_count = count_q;
    assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed self-checking bench for the serial pattern detector
module tb_seq_detect_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_detect_ctrl_if #(.MAXLEN(8), .CW(8)) ifc ();

    seq_detect_ctrl #(.MAXLEN(8), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        ifc.cfg_valid   = 1'b0;
        ifc.cfg_pattern = '0;
        ifc.cfg_len     = 4'd0;
        ifc.cfg_overlap = 1'b0;
        ifc.cfg_target  = '0;
        ifc.start       = 1'b0;
        ifc.abort       = 1'b0;
        ifc.x           = 1'b0;
        ifc.x_valid     = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                       input logic [7:0] tgt, input logic st);
        @(negedge clk);
        ifc.x_valid     = 1'b0;
        ifc.cfg_valid   = 1'b1;
        ifc.cfg_pattern = pat;
        ifc.cfg_len     = len;
        ifc.cfg_overlap = ov;
        ifc.cfg_target  = tgt;
        ifc.start       = st;
        @(negedge clk);
        ifc.cfg_valid   = 1'b0;
        ifc.start       = 1'b0;
    endtask

    task automatic send(input logic b, input logic v, output logic yo);
        @(negedge clk);
        ifc.x       = b;
        ifc.x_valid = v;
        #1 yo = ifc.y;
    endtask

    // Streams n bits MSB first; gated inserts an x_valid=0 junk cycle after each bit
    task automatic stream(input logic [15:0] bits, input int n, input bit gated,
                          output logic [15:0] obs, output int bad);
        logic yo;
        obs = '0;
        bad = 0;
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], 1'b1, yo);
            obs = {obs[14:0], yo};
            if (gated) begin
                send(~bits[i], 1'b0, yo);
                if (yo) bad++;
            end
        end
        @(negedge clk);
        ifc.x_valid = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (ifc.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", ifc.cfg_ready); end
        checks++; if (ifc.busy !== 1'b0 || ifc.y !== 1'b0 || ifc.done !== 1'b0 || ifc.cfg_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b y=%b done=%b err=%b want 0", ifc.busy, ifc.y, ifc.done, ifc.cfg_err); end
        checks++; if (ifc.match_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ifc.match_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_nonoverlap();
        logic [15:0] obs;
        int bad;
        cfg(8'b101, 4'd3, 1'b0, 8'd0, 1'b1);
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", ifc.busy); end
        stream(16'h05C5, 13, 1'b0, obs, bad);
        checks++; if (obs !== 16'h0101) begin errors++; $display("FAIL nonoverlap_y got %h want 0101", obs); end
        checks++; if (ifc.match_count !== 8'd2) begin errors++; $display("FAIL nonoverlap_count got %0d want 2", ifc.match_count); end
        do_abort();
    endtask

    task automatic test_overlap_modes();
        logic [15:0] obs;
        int bad;
        cfg(8'b101, 4'd3, 1'b0, 8'd0, 1'b1);
        stream(16'h0015, 5, 1'b0, obs, bad);
        checks++; if (obs !== 16'h0004 || ifc.match_count !== 8'd1) begin
            errors++; $display("FAIL ov0_10101 got y=%h cnt=%0d want 0004 cnt=1", obs, ifc.match_count); end
        do_abort();
        cfg(8'b101, 4'd3, 1'b1, 8'd0, 1'b1);
        stream(16'h0015, 5, 1'b0, obs, bad);
        checks++; if (obs !== 16'h0005 || ifc.match_count !== 8'd2) begin
            errors++; $display("FAIL ov1_10101 got y=%h cnt=%0d want 0005 cnt=2", obs, ifc.match_count); end
        do_abort();
    endtask

    task automatic test_long_target();
        logic [15:0] obs;
        logic yo;
        cfg(8'b11010011, 4'd8, 1'b1, 8'd2, 1'b1);
        obs = '0;
        for (int i = 15; i >= 0; i--) begin
            send(i[3] ? 1'b1 : 1'b1, 1'b1, yo);
            obs = obs;
            break;
        end
        obs = '0;
        ifc.x_valid = 1'b0;
        do_abort();
        cfg(8'b11010011, 4'd8, 1'b1, 8'd2, 1'b1);
        for (int i = 15; i >= 0; i--) begin
            logic [15:0] s;
            s = 16'hD3D3;
            send(s[i], 1'b1, yo);
            obs = {obs[14:0], yo};
        end
        @(negedge clk);
        ifc.x_valid = 1'b0;
        #1;
        checks++; if (obs !== 16'h0101) begin errors++; $display("FAIL long_y got %h want 0101", obs); end
        checks++; if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
            errors++; $display("FAIL long_done got done=%b busy=%b want done=1 busy=0", ifc.done, ifc.busy); end
        checks++; if (ifc.match_count !== 8'd2) begin errors++; $display("FAIL long_count got %0d want 2", ifc.match_count); end
        @(negedge clk);
        #1;
        checks++; if (ifc.done !== 1'b0 || ifc.cfg_ready !== 1'b1 || ifc.match_count !== 8'd2) begin
            errors++; $display("FAIL long_after got done=%b ready=%b cnt=%0d want 0 1 2", ifc.done, ifc.cfg_ready, ifc.match_count); end
    endtask

    task automatic test_gated();
        logic [15:0] obs;
        int bad;
        cfg(8'b101, 4'd3, 1'b0, 8'd0, 1'b1);
        stream(16'h05C5, 13, 1'b1, obs, bad);
        checks++; if (obs !== 16'h0101) begin errors++; $display("FAIL gated_y got %h want 0101", obs); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL gated_invalid_y got %0d strobes want 0", bad); end
        checks++; if (ifc.match_count !== 8'd2) begin errors++; $display("FAIL gated_count got %0d want 2", ifc.match_count); end
        do_abort();
    endtask

    task automatic test_abort();
        logic [15:0] obs;
        logic yo;
        int bad;
        cfg(8'b101, 4'd3, 1'b0, 8'd0, 1'b1);
        stream(16'h0016, 5, 1'b0, obs, bad);
        checks++; if (obs !== 16'h0004) begin errors++; $display("FAIL abort_pre_y got %h want 0004", obs); end
        @(negedge clk);
        ifc.x       = 1'b1;
        ifc.x_valid = 1'b1;
        ifc.abort   = 1'b1;
        #1 yo = ifc.y;
        checks++; if (yo !== 1'b0) begin errors++; $display("FAIL abort_y got %b want 0", yo); end
        @(negedge clk);
        ifc.abort   = 1'b0;
        ifc.x_valid = 1'b0;
        #1;
        checks++; if (ifc.busy !== 1'b0 || ifc.cfg_ready !== 1'b1 || ifc.done !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b ready=%b done=%b want 0 1 0", ifc.busy, ifc.cfg_ready, ifc.done); end
        checks++; if (ifc.match_count !== 8'd1) begin errors++; $display("FAIL abort_count got %0d want 1", ifc.match_count); end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] obs;
        logic yo;
        int bad;
        cfg(8'b101, 4'd3, 1'b0, 8'd0, 1'b1);
        stream(16'h0016, 5, 1'b0, obs, bad);
        send(1'b1, 1'b1, yo);
        checks++; if (yo !== 1'b1) begin errors++; $display("FAIL midrun_y got %b want 1", yo); end
        reset = 1'b1;
        #1;
        checks++; if (ifc.y !== 1'b0 || ifc.busy !== 1'b0 || ifc.cfg_ready !== 1'b1 || ifc.match_count !== 8'd0) begin
            errors++; $display("FAIL midrun_reset got y=%b busy=%b ready=%b cnt=%0d want 0 0 1 0", ifc.y, ifc.busy, ifc.cfg_ready, ifc.match_count); end
        @(negedge clk);
        reset = 1'b0;
        ifc.x_valid = 1'b0;
        #1;
        checks++; if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
            errors++; $display("FAIL midrun_after got done=%b busy=%b want 0 0", ifc.done, ifc.busy); end
    endtask

    task automatic test_cfg_err();
        logic [15:0] obs;
        int bad;
        cfg(8'b101, 4'd3, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ifc.cfg_valid   = 1'b1;
            ifc.cfg_pattern = 8'hFF;
            ifc.cfg_len     = (k == 0) ? 4'd1 : 4'd9;
            ifc.cfg_overlap = 1'b1;
            #1;
            checks++; if (ifc.cfg_ready !== 1'b1 || ifc.cfg_err !== 1'b0) begin
                errors++; $display("FAIL cfg_err_pre%0d got ready=%b err=%b want 1 0", k, ifc.cfg_ready, ifc.cfg_err); end
            @(negedge clk);
            ifc.cfg_valid = 1'b0;
            #1;
            checks++; if (ifc.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse%0d got %b want 1", k, ifc.cfg_err); end
            @(negedge clk);
            #1;
            checks++; if (ifc.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear%0d got %b want 0", k, ifc.cfg_err); end
        end
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start       = 1'b0;
        ifc.cfg_valid   = 1'b1;
        ifc.cfg_pattern = 8'b11;
        ifc.cfg_len     = 4'd2;
        #1;
        checks++; if (ifc.cfg_ready !== 1'b0) begin errors++; $display("FAIL run_cfg_ready got %b want 0", ifc.cfg_ready); end
        @(negedge clk);
        ifc.cfg_valid = 1'b0;
        #1;
        checks++; if (ifc.cfg_err !== 1'b0) begin errors++; $display("FAIL run_cfg_err got %b want 0", ifc.cfg_err); end
        stream(16'h005D, 7, 1'b0, obs, bad);
        checks++; if (obs !== 16'h0011 || ifc.match_count !== 8'd2) begin
            errors++; $display("FAIL cfg_kept got y=%h cnt=%0d want 0011 cnt=2", obs, ifc.match_count); end
        do_abort();
    endtask

    task automatic test_saturate();
        logic yo;
        cfg(8'b11, 4'd2, 1'b1, 8'd0, 1'b1);
        for (int i = 0; i < 262; i++) send(1'b1, 1'b1, yo);
        @(negedge clk);
        ifc.x_valid = 1'b0;
        #1;
        checks++; if (ifc.match_count !== 8'd255 || ifc.busy !== 1'b1) begin
            errors++; $display("FAIL saturate got cnt=%0d busy=%b want 255 1", ifc.match_count, ifc.busy); end
        do_abort();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_nonoverlap();
        test_overlap_modes();
        test_long_target();
        test_gated();
        test_abort();
        test_reset_midrun();
        test_cfg_err();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
